// File: rtl/rf_pkg.sv
// Shared register-file constants and write-port FSM state type.
package rf_pkg;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = 3;
    localparam int DATA_W   = 32;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;
endpackage

// File: rtl/rf8x32_write_port_3to8_decoder.sv
// One-hot register select from a 3-bit index; all zeros when not enabled.
module rf8x32_write_port_3to8_decoder (
    input  logic [2:0] addr,
    input  logic       en,
    output logic [7:0] sel
);
    always_comb begin
        sel = '0;
        if (en) begin
            sel[addr] = 1'b1;
        end
    end
endmodule

// File: rtl/rf8x32_write_port.sv
// Write side of the 8x32 register file: byte-masked writes, 8-cycle sequential clear.
// Writes appear on q one cycle after acceptance; ready drops for the whole clear sequence.
module rf8x32_write_port #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 8,
    parameter int CNT_W    = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          we,
    input  logic [rf_pkg::ADDR_W-1:0]     wAddr,
    input  logic [DATA_W-1:0]             wData,
    input  logic [DATA_W/8-1:0]           wMask,
    input  logic                          clr,
    output logic                          ready,
    output logic                          busy,
    output logic [DATA_W-1:0]             q0,
    output logic [DATA_W-1:0]             q1,
    output logic [DATA_W-1:0]             q2,
    output logic [DATA_W-1:0]             q3,
    output logic [DATA_W-1:0]             q4,
    output logic [DATA_W-1:0]             q5,
    output logic [DATA_W-1:0]             q6,
    output logic [DATA_W-1:0]             q7,
    output logic [CNT_W-1:0]              wr_cnt
);
    import rf_pkg::*;

    state_t                   state;
    logic [ADDR_W-1:0]        clr_ptr;
    logic [DATA_W-1:0]        regs [NUM_REGS];
    logic [7:0]               wr_sel;
    logic [7:0]               clr_sel;
    logic                     wr_accept;

    assign ready = (state == IDLE);
    assign busy  = (state == CLEAR);

    // A clear request in the same cycle as a write wins; the write is dropped.
    assign wr_accept = we & ready & ~clr;

    rf8x32_write_port_3to8_decoder u_wr_dec (
        .addr (wAddr),
        .en   (wr_accept),
        .sel  (wr_sel)
    );

    rf8x32_write_port_3to8_decoder u_clr_dec (
        .addr (clr_ptr),
        .en   (busy),
        .sel  (clr_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_ptr <= '0;
            wr_cnt  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end else if (we) begin
                        wr_cnt <= wr_cnt + 1'b1;
                    end
                end
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == ADDR_W'(NUM_REGS - 1)) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_sel[i]) begin
                    regs[i] <= '0;
                end else if (wr_sel[i]) begin
                    for (int b = 0; b < DATA_W / 8; b++) begin
                        if (wMask[b]) begin
                            regs[i][8*b +: 8] <= wData[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    assign q0 = regs[0];
    assign q1 = regs[1];
    assign q2 = regs[2];
    assign q3 = regs[3];
    assign q4 = regs[4];
    assign q5 = regs[5];
    assign q6 = regs[6];
    assign q7 = regs[7];
endmodule

// File: doc/rf8x32_write_port.md
Name: rf8x32_write_port

Overview:
- Write side of the 8-entry x 32-bit register file; owns the storage the 8-to-1 read mux selects from.
- Takes write requests (address, data, byte mask) and updates one register per accepted request.
- Supports a multi-cycle clear command that zeroes all eight registers sequentially.
- Drives q0..q7 straight into the read mux, plus status outputs for the controller.

Parameters:
- DATA_W, 32, register width in bits; must be a multiple of 8.
- NUM_REGS, 8, number of registers; fixed at 8 to match the 3-bit address.
- CNT_W, 8, width of the accepted-write counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- we  input  1  write request, qualified by ready.
- wAddr  input  3  target register index.
- wData  input  DATA_W  write data.
- wMask  input  DATA_W/8  byte enables; bit i enables wData[8i+7:8i].
- clr  input  1  request a clear-all sequence.
- ready  output  1  high when a write or clear can be accepted.
- busy  output  1  high while a clear sequence is running.
- q0..q7  output  DATA_W each  current register contents, to the read mux.
- wr_cnt  output  CNT_W  count of accepted writes.

Behaviour:
- Clock and reset are fixed: single clock clk; reset is synchronous and active-high. It is sampled only on the rising edge of clk.
- Reset values:
  - q0..q7 = 0.
  - wr_cnt = 0.
  - state = IDLE, clr_ptr = 0.
  - ready = 1, busy = 0.
- FSM states: IDLE, CLEAR.
  - ready = (state == IDLE); busy = (state == CLEAR). Both are decoded combinationally from state.
- In IDLE, evaluated at each edge in priority order:
  1. clr=1: go to CLEAR with clr_ptr=0. A simultaneous we is dropped: no data change, no count.
  2. we=1: register[wAddr] byte i gets wData byte i for every wMask[i]=1. Unmasked bytes hold. wr_cnt increments by 1.
- Write latency: new value visible on q<wAddr> one cycle after the accepting edge. No combinational path from wData to q.
- wMask=0 with we=1: accepted and counted, but no data change.
- Back-to-back writes to the same address in consecutive cycles: each applies in order, last wins per byte.
- wr_cnt wraps modulo 2^CNT_W (255 -> 0). It is not cleared by clr, only by reset.
- In CLEAR:
  - Each cycle, register[clr_ptr] = 0 and clr_ptr increments.
  - After the edge that clears index 7, return to IDLE.
  - The sequence takes exactly 8 cycles: ready is low for 8 cycles after the accepting edge.
  - we and clr are ignored in CLEAR; no writes, no counting, no restart.
  - Registers not yet reached by clr_ptr keep their old values until cleared.
- Reset mid-CLEAR: the next edge forces all registers to 0, state to IDLE and wr_cnt to 0.
- Reset has priority over every other input.

Decomposition:
- Shared package rf_pkg:
  - Constants NUM_REGS=8, ADDR_W=3, DATA_W=32.
  - State typedef {IDLE, CLEAR}.
  - Also imported by the read-mux testbench.
- One natural sub-module: _3to8_decoder.
  - Takes address and enable, returns a one-hot 8-bit select.
  - Shared by the write path (wAddr, we&ready) and the clear path (clr_ptr, busy).

Test Plan:
- Reset then idle: hold reset 2 cycles -> q0..q7=0, wr_cnt=0, ready=1, busy=0.
- Full write: we=1, wAddr=5, wData=32'hDEADBEEF, wMask=4'hF for 1 cycle -> next cycle q5=DEADBEEF, others 0, wr_cnt=1.
- Partial write: with q5=DEADBEEF, write wAddr=5, wData=32'h11223344, wMask=4'b0101 -> q5=DE22BE44, wr_cnt=2.
- Clear sequence:
  - Stimulus: fill q0..q7 with 1..8, then pulse clr. Hold we=1 throughout to wAddr=0 with data FFFFFFFF.
  - Required: ready=0 and busy=1 for exactly 8 cycles, and q0..q7 zero in index order.
  - Required: no write lands and wr_cnt is unchanged. On the 9th cycle ready=1 and the held write lands in q0.
- Simultaneous clr and we in IDLE: clr=1, we=1, wAddr=3, data 0000AAAA -> CLEAR entered, q3 never becomes 0000AAAA, wr_cnt unchanged.
- Wrap and reset mid-clear:
  - Issue 256 writes -> wr_cnt returns to 0.
  - Start clear, assert reset on its 4th cycle -> next cycle all q=0, IDLE, ready=1, wr_cnt=0.
